// File: rtl/progmem_loader_if.sv
// Byte-stream, control/status and progmem port-B signals of the program RAM loader.
// The master side (stream source + RAM model) drives doutb; the loader is the slave.
interface progmem_loader_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          start;
  logic [AW:0]   num_words;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dinb;
  logic          web;
  logic          enb;
  logic [DW-1:0] doutb;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] err_addr;

  modport master (
    output start, num_words, byte_data, byte_valid, doutb,
    input  byte_ready, addrb, dinb, web, enb, busy, done, error, err_addr
  );

  modport slave (
    input  start, num_words, byte_data, byte_valid, doutb,
    output byte_ready, addrb, dinb, web, enb, busy, done, error, err_addr
  );
endinterface

// File: rtl/progmem_loader.sv
// Packs a little-endian byte stream into 32-bit words, writes them to progmem port B
// from address 0 upward, reads each word back and records the first verify mismatch.
module progmem_loader #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rstn,
  progmem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_READ, S_CHECK, S_DONE
  } state_t;

  localparam logic [AW:0] NW_MAX = {1'b1, {AW{1'b0}}};

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [DW-1:0] word_q, word_d;
  logic [DW-1:0] dinb_q, dinb_d;
  logic [AW:0]   nwords_q, nwords_d;
  logic          error_q, error_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      dinb_q     <= '0;
      nwords_q   <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      dinb_q     <= dinb_d;
      nwords_q   <= nwords_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    byte_cnt_d     = byte_cnt_q;
    word_d         = word_q;
    dinb_d         = dinb_q;
    nwords_d       = nwords_q;
    error_d        = error_q;
    err_addr_d     = err_addr_q;
    bus.byte_ready = 1'b0;
    bus.web        = 1'b0;
    bus.enb        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          error_d    = 1'b0;
          err_addr_d = '0;
          if (bus.num_words != '0) begin
            nwords_d   = (bus.num_words > NW_MAX) ? NW_MAX : bus.num_words;
            addr_d     = '0;
            byte_cnt_d = '0;
            state_d    = S_COLLECT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_COLLECT: begin
        bus.byte_ready = 1'b1;
        if (bus.byte_valid) begin
          word_d[8*byte_cnt_q +: 8] = bus.byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Last byte goes straight into the write register so web follows next cycle.
          if (byte_cnt_q == 2'd3) begin
            dinb_d  = {bus.byte_data, word_q[DW-9:0]};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        bus.enb = 1'b1;
        bus.web = 1'b1;
        state_d = S_READ;
      end
      S_READ: begin
        bus.enb = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bus.doutb != dinb_q) begin
          error_d = 1'b1;
          if (!error_q) err_addr_d = addr_q;
        end
        if ({1'b0, addr_q} == nwords_q - (AW+1)'(1)) begin
          state_d = S_DONE;
        end else begin
          addr_d     = addr_q + AW'(1);
          byte_cnt_d = '0;
          state_d    = S_COLLECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.addrb    = addr_q;
  assign bus.dinb     = dinb_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.error    = error_q;
  assign bus.err_addr = err_addr_q;

endmodule

// File: tb/tb_progmem_loader.sv
// Directed + randomized bench for progmem_loader with a 512x32 synchronous RAM model on
// port B, a write monitor, and expectations derived from the byte stream per load.
module tb_progmem_loader;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  progmem_loader_if #(.AW(9), .DW(32)) bus();
  progmem_loader #(.AW(9), .DW(32)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

  int tests = 0;
  int failed = 0;

  // RAM model: port B signals are captured mid-cycle and applied at the rising edge.
  logic [31:0] mem [512];
  bit          corrupt [512];
  logic        en_s = 1'b0, we_s = 1'b0;
  logic [8:0]  a_s = '0;
  logic [31:0] d_s = '0;

  always @(negedge clk) begin
    en_s <= bus.enb;
    we_s <= bus.web;
    a_s  <= bus.addrb;
    d_s  <= bus.dinb;
  end

  always @(posedge clk) begin
    if (en_s) begin
      if (we_s) mem[a_s] <= d_s;
      else      bus.doutb <= mem[a_s] ^ (corrupt[a_s] ? 32'h0000_0100 : 32'h0);
    end
  end

  // Free-running monitors; each load works on deltas.
  int          wr_cnt = 0, enb_cnt = 0, done_cnt = 0;
  logic [8:0]  wr_addr [4096];
  logic [31:0] wr_data [4096];

  always @(negedge clk) begin
    if (bus.enb && bus.web) begin
      wr_addr[wr_cnt % 4096] <= bus.addrb;
      wr_data[wr_cnt % 4096] <= bus.dinb;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.enb)  enb_cnt  <= enb_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tg);
    chk({tg, "_ctl"}, 32'({bus.byte_ready, bus.busy, bus.done, bus.error, bus.web, bus.enb}), 0);
    chk({tg, "_addrb"}, 32'(bus.addrb), 0);
    chk({tg, "_dinb"}, bus.dinb, 0);
    chk({tg, "_err_addr"}, 32'(bus.err_addr), 0);
  endtask

  byte unsigned bq[$];
  byte unsigned fixq[$];

  // One load: start, feed the stream (mode 0 steady, 1 toggling, 2 random gaps),
  // optionally pulse start mid-load, then compare against the stream-derived model.
  task automatic run_load(input string tg, input int nw, input int nb, input int mode, input bit poke);
    byte unsigned eb[$];
    int n, cyc, bw, be, bd, hs, bad;
    bit v, hs_now, exp_err;
    logic [8:0]  exp_ea;
    logic [31:0] w;
    if (fixq.size() != 0) begin
      bq = fixq;
      fixq = {};
    end else begin
      bq = {};
      for (int i = 0; i < nb; i++) bq.push_back(8'($urandom));
    end
    eb = bq;
    n = (nw > 512) ? 512 : nw;
    @(negedge clk);
    bw = wr_cnt; be = enb_cnt; bd = done_cnt; hs = 0;
    bus.num_words = 10'(nw);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (n == 0) chk({tg, "_done_lat"}, 32'(bus.done), 1);
    else        chk({tg, "_busy"}, 32'(bus.busy), 1);
    cyc = 0;
    while (!bus.done && cyc < 20000) begin
      case (mode)
        0:       v = (bq.size() != 0);
        1:       v = (bq.size() != 0) && !cyc[0];
        default: v = (bq.size() != 0) && ($urandom_range(0, 3) != 0);
      endcase
      bus.byte_valid = v;
      bus.byte_data  = v ? bq[0] : 8'h00;
      bus.start      = poke && (cyc == 9);
      bus.num_words  = (poke && cyc == 9) ? 10'd1 : 10'(nw);
      hs_now = v && bus.byte_ready;
      @(posedge clk);
      if (hs_now) begin
        void'(bq.pop_front());
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.byte_valid = 1'b0;
    bus.start = 1'b0;
    bus.num_words = '0;
    chk({tg, "_no_timeout"}, 32'(cyc < 20000), 1);
    repeat (3) @(negedge clk);
    chk({tg, "_done_pulses"}, 32'(done_cnt - bd), 1);
    chk({tg, "_writes"}, 32'(wr_cnt - bw), 32'(n));
    chk({tg, "_handshakes"}, 32'(hs), 32'(4 * n));
    chk({tg, "_enb_cycles"}, 32'(enb_cnt - be), 32'(2 * n));
    bad = 0;
    exp_err = 1'b0;
    exp_ea = '0;
    for (int i = 0; i < n; i++) begin
      w = {eb[4*i+3], eb[4*i+2], eb[4*i+1], eb[4*i]};
      if (wr_addr[(bw + i) % 4096] !== 9'(i) || wr_data[(bw + i) % 4096] !== w || mem[i] !== w) bad++;
      if (corrupt[i] && !exp_err) begin
        exp_err = 1'b1;
        exp_ea = 9'(i);
      end
    end
    chk({tg, "_word_errs"}, 32'(bad), 0);
    chk({tg, "_error"}, 32'(bus.error), 32'(exp_err));
    chk({tg, "_err_addr"}, 32'(bus.err_addr), 32'(exp_ea));
    chk({tg, "_idle"}, 32'(bus.busy), 0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.num_words = '0;
    bus.byte_data = '0;
    bus.byte_valid = 1'b0;
    for (int i = 0; i < 512; i++) corrupt[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;

    fixq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("t1", 2, 8, 0, 0);
    chk("t1_ram0", mem[0], 32'h1234_5678);
    chk("t1_ram1", mem[1], 32'hDEAD_BEEF);

    run_load("t2", 1, 6, 1, 0);
    chk("t2_left", 32'(bq.size()), 2);

    run_load("t3", 0, 0, 0, 0);

    corrupt[3] = 1'b1;
    corrupt[5] = 1'b1;
    run_load("t4", 8, 32, 0, 0);
    corrupt[3] = 1'b0;
    corrupt[5] = 1'b0;

    run_load("t5", 600, 2056, 0, 0);

    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = $urandom_range(1, 20);
      for (int i = 0; i < 32; i++) corrupt[i] = ($urandom_range(0, 5) == 0);
      run_load($sformatf("rnd%0d", r), nw, 4 * nw + 3, 2, r[0]);
    end
    for (int i = 0; i < 32; i++) corrupt[i] = 1'b0;

    // Reset after two of four bytes: everything clears, then a fresh single-word load.
    @(negedge clk);
    bus.num_words = 10'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'hA5;
    @(negedge clk);
    bus.byte_data = 8'h5A;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk_zero("t6_rst");
    @(negedge clk);
    rstn = 1'b1;
    run_load("t6", 1, 4, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
